mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 12-bit-address / 8-bit-data program/data RAM between NUM_REQ
//  requesters: the CPU core plus a program loader or debug port.
//  Round-robin grant with a per-requester lock, so a multi-byte CPU instruction
//  fetch/operand sequence is never split by another master.
//  Sits between the requesters and the synchronous RAM. One memory access per 2 cycles.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2); index 0 = CPU
//  ADDR_WIDTH  12  memory address width
//  DATA_WIDTH  8   memory data width
// PORTS
//  clock      in   1                     system clock, rising edge
//  reset      in   1                     asynchronous, active-high reset
//  req        in   NUM_REQ               per-requester access request, held until gnt
//  we         in   NUM_REQ               1 = write, 0 = read (valid with req)
//  lock       in   NUM_REQ               keep ownership after this access
//  addr       in   NUM_REQ*ADDR_WIDTH    packed request addresses, requester i at [i*AW +: AW]
//  wdata      in   NUM_REQ*DATA_WIDTH    packed write data
//  gnt        out  NUM_REQ               one-hot, 1-cycle pulse: request accepted
//  rvalid     out  NUM_REQ               one-hot, 1-cycle pulse: rdata valid for requester
//  rdata      out  DATA_WIDTH            read data (mem_rdata pass-through)
//  mem_addr   out  ADDR_WIDTH            RAM address
//  mem_wdata  out  DATA_WIDTH            RAM write data
//  mem_we     out  1                     RAM write strobe
//  mem_re     out  1                     RAM read strobe
//  mem_rdata  in   DATA_WIDTH            RAM read data, valid the cycle after mem_re
// BEHAVIOUR
//  Reset (async, immediate)
//   - state=IDLE, rr_ptr=0, owner=none, locked=0.
//   - gnt, rvalid, mem_we, mem_re, mem_addr, mem_wdata all 0.
//   - An in-flight access is aborted: a write mid-ACCESS is dropped, no rvalid issued.
//  FSM states: IDLE, ACCESS, RESP
//   - IDLE: if any req, capture winner w (addr/we/wdata into regs) -> ACCESS, gnt[w]=1 in ACCESS.
//   - ACCESS (1 cycle): mem_addr/mem_wdata from captured regs; mem_we=we_r, mem_re=~we_r;
//     gnt[w] high this cycle only. Always -> RESP.
//   - RESP (1 cycle): rvalid[w]=1 if read, rdata=mem_rdata.
//     Arbitrates again: if a capture occurs -> ACCESS, else -> IDLE.
//   - Requester sees gnt in ACCESS and must present its next request (or drop req)
//     by RESP; req is never sampled in ACCESS.
//   - Latency: req rising in IDLE at cycle t -> gnt at t+1 -> rvalid/rdata at t+2.
//     Back-to-back from RESP: capture at t+2, gnt t+3, rvalid t+4.
//  Arbitration
//   - Round-robin: search starts at rr_ptr, lowest index wins after wrap
//     (NUM_REQ-1 -> 0).
//   - On capture: rr_ptr <= (w+1) mod NUM_REQ.
//   - Lock: at capture, locked <= lock[w]. While locked, only owner w is eligible;
//     other reqs wait indefinitely. rr_ptr is not advanced by locked captures.
//   - Lock release: owner captured with lock[w]=0, or owner not requesting when
//     arbitration runs (locked<=0, normal RR resumes in the same decision).
//   - No request pending with locked=1 -> IDLE keeps locked=1 until owner requests
//     again or deasserts lock (lock[w]=0 sampled in IDLE clears it).
//  Boundary conditions
//   - Simultaneous req from all masters: exactly one gnt; fairness = every requester
//     served within NUM_REQ unlocked grants.
//   - Write: no rvalid pulse.
//   - Outputs gnt/rvalid are registered and never more than one bit set.
//  Widths: addresses/data pass unmodified; no arithmetic on data paths;
//   rr_ptr is $clog2(NUM_REQ) bits with explicit wrap.
// STRUCTURE
//  - Shared package: state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2),
//    default ADDR/DATA widths (12/8), shared with the CPU and RAM blocks.
//  - Sub-module rr_picker: combinational round-robin one-hot pick from (eligible mask,
//    rr_ptr); also reused by future I/O arbiters.
//  - Top holds FSM, captured-request registers, owner/locked, rr_ptr, output regs.
// TESTING
//  1. Reset mid-write: req0 we=1 addr=12'h123; assert reset during ACCESS
//     -> mem_we drops immediately, no gnt/rvalid, RAM[0x123] unchanged.
//  2. Single read: req1 addr=12'h0A5, RAM=8'h3C
//     -> gnt[1] at t+1, mem_re+mem_addr=0x0A5 at t+1, rvalid[1]+rdata=8'h3C at t+2.
//  3. Contention, no lock: req=2'b11 held, both reads
//     -> grants alternate 0,1,0,1 with rr_ptr wrap; each gnt 2 cycles apart.
//  4. Lock: req0 lock=1 for 3 back-to-back reads at 0x010..0x012 while req1 held
//     -> gnt[0] x3 before any gnt[1]; gnt[1] on the capture after lock[0] drops.
//  5. Write then read same address: req1 write 8'hA7 @0xFFF, then read @0xFFF
//     -> mem_we 1 cycle, no rvalid; read returns 8'hA7.
//  6. Idle with stale lock: owner 0 locks, drops req and lock in IDLE
//     -> locked clears; next req1 is granted in the following cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: FSM encoding, default
// bus widths and a small index-wrap helper.
package mem_bus_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Next requester index with explicit wrap to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake and RAM-side signals of the arbiter.
// The slave modport is the arbiter; the master modport is requesters plus RAM.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic                          mem_we;
  logic                          mem_re;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping past N-1 back to 0.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          valid
);

  always_comb begin
    int idx;
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && eligible[idx]) begin
        pick[idx] = 1'b1;
        pick_idx  = PW'(idx);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter with per-requester lock in front of the synchronous
// program/data RAM; one access every two cycles.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  // state  | meaning
  // IDLE   | no access in flight, arbitrating every cycle
  // ACCESS | RAM strobe and gnt for the captured request
  // RESP   | rvalid for reads, arbitrating for the next access

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e state, state_d;

  logic [PW-1:0]         rr_ptr, rr_ptr_d;
  logic [PW-1:0]         owner, owner_d;
  logic                  locked, locked_d;
  logic [PW-1:0]         cur, cur_d;
  logic                  we_r, we_d;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]    owner_oh;
  logic [NUM_REQ-1:0]    cur_oh;
  logic                  hold;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    pick;
  logic [PW-1:0]         pick_idx;
  logic                  pick_valid;

  assign owner_oh = NUM_REQ'(1) << owner;
  assign cur_oh   = NUM_REQ'(1) << cur;

  // A lock only holds off others while the owner is still asking; an absent
  // owner releases it within the same decision.
  assign hold     = locked && bus.req[owner];
  assign eligible = hold ? owner_oh : bus.req;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    owner_d     = owner;
    locked_d    = locked;
    cur_d       = cur;
    we_d        = we_r;
    gnt_d       = '0;
    rvalid_d    = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state)
      ACCESS: begin
        state_d = RESP;
        if (!we_r) rvalid_d = cur_oh;
      end
      IDLE, RESP: begin
        if (pick_valid) begin
          state_d     = ACCESS;
          cur_d       = pick_idx;
          owner_d     = pick_idx;
          locked_d    = bus.lock[pick_idx];
          we_d        = bus.we[pick_idx];
          gnt_d       = pick;
          mem_we_d    = bus.we[pick_idx];
          mem_re_d    = !bus.we[pick_idx];
          mem_addr_d  = bus.addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = bus.wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          if (!hold) rr_ptr_d = PW'(wrap_inc(int'(pick_idx), NUM_REQ));
        end else begin
          state_d = IDLE;
          if (!bus.lock[owner]) locked_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      cur         <= '0;
      we_r        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      owner       <= owner_d;
      locked      <= locked_d;
      cur         <= cur_d;
      we_r        <= we_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = bus.mem_rdata;

endmodule
